mem_stage: RTL and testbench

Memory-access stage of the rv32i pipeline, directly downstream of execute. Consumes the ALU result as an effective address (or pass-through result) plus the rs2 store operand. Runs RV32I loads and stores (byte, half, word) on a single-outstanding request/ready data-memory bus, with sign or zero extension. Drives registered writeback outputs and a stall back to the earlier stages while a bus access is in flight.

---
 rtl/mem_stage.sv | 208 ++++++++++++++++++++
 tb/tb_mem_stage.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// RV32I memory-access stage: formats loads/stores onto a single-outstanding
// request/ready data bus and drives registered writeback outputs plus a stall.
module mem_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic        flush,
    input  logic [31:0] alu_out,
    input  logic [31:0] store_data,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [2:0]  funct3,
    input  logic [4:0]  rd,
    input  logic        reg_write,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_wstrb,
    input  logic        dmem_ready,
    input  logic [31:0] dmem_rdata,
    output logic        stall,
    output logic        wb_valid,
    output logic        wb_reg_write,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        mem_fault
);

    typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_BUSY = 1'b1} state_e;

    // Illegal width, misalignment, or simultaneous read and write.
    function automatic logic op_fault(input logic rd_en, input logic wr_en,
                                      input logic [2:0] f3, input logic [1:0] a);
        logic ok;
        case (f3)
            3'b000, 3'b100: ok = 1'b1;
            3'b001, 3'b101: ok = ~a[0];
            3'b010:         ok = (a == 2'b00);
            default:        ok = 1'b0;
        endcase
        return ~ok | (rd_en & wr_en);
    endfunction

    function automatic logic [31:0] load_extract(input logic [2:0] f3, input logic [1:0] lane,
                                                 input logic [31:0] rdata);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (lane)
            2'd0:    b = rdata[7:0];
            2'd1:    b = rdata[15:8];
            2'd2:    b = rdata[23:16];
            default: b = rdata[31:24];
        endcase
        h = lane[1] ? rdata[31:16] : rdata[15:0];
        case (f3)
            3'b000:  r = {{24{b[7]}}, b};
            3'b100:  r = {24'h000000, b};
            3'b001:  r = {{16{h[15]}}, h};
            3'b101:  r = {16'h0000, h};
            3'b010:  r = rdata;
            default: r = 32'h0000_0000;
        endcase
        return r;
    endfunction

    state_e      state_q;
    logic        req_q, we_q, load_q, regw_q, flush_seen_q;
    logic [31:0] addr_q, wdata_q;
    logic [3:0]  wstrb_q;
    logic [1:0]  lane_q;
    logic [2:0]  funct3_q;
    logic [4:0]  rd_q;
    logic        wb_valid_q, wb_reg_write_q, mem_fault_q;
    logic [4:0]  wb_rd_q;
    logic [31:0] wb_data_q;

    logic        mem_op_s, fault_s, accept_s, stall_s;
    logic [31:0] wdata_d;
    logic [3:0]  wstrb_d;

    assign mem_op_s = mem_read | mem_write;
    assign fault_s  = op_fault(mem_read, mem_write, funct3, alu_out[1:0]);
    assign accept_s = (state_q == ST_IDLE) & in_valid & ~flush & mem_op_s & ~fault_s;

    // Lane-replicated store data and byte enables for the incoming op.
    always_comb begin
        wdata_d = store_data;
        wstrb_d = 4'b0000;
        if (mem_write) begin
            case (funct3[1:0])
                2'b00: begin
                    wdata_d = {4{store_data[7:0]}};
                    wstrb_d = 4'b0001 << alu_out[1:0];
                end
                2'b01: begin
                    wdata_d = {2{store_data[15:0]}};
                    wstrb_d = 4'b0011 << alu_out[1:0];
                end
                default: begin
                    wdata_d = store_data;
                    wstrb_d = 4'b1111;
                end
            endcase
        end else begin
            wstrb_d = 4'b0000;
        end
    end

    // Stall is the only combinational output: accept in IDLE, wait in BUSY.
    always_comb begin
        stall_s = 1'b0;
        case (state_q)
            ST_IDLE: stall_s = accept_s;
            ST_BUSY: stall_s = ~dmem_ready;
            default: stall_s = 1'b0;
        endcase
    end

    // Stage FSM: request latching, bus handshake and writeback registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            req_q          <= 1'b0;
            we_q           <= 1'b0;
            load_q         <= 1'b0;
            regw_q         <= 1'b0;
            flush_seen_q   <= 1'b0;
            addr_q         <= 32'h0000_0000;
            wdata_q        <= 32'h0000_0000;
            wstrb_q        <= 4'b0000;
            lane_q         <= 2'b00;
            funct3_q       <= 3'b000;
            rd_q           <= 5'd0;
            wb_valid_q     <= 1'b0;
            wb_reg_write_q <= 1'b0;
            wb_rd_q        <= 5'd0;
            wb_data_q      <= 32'h0000_0000;
            mem_fault_q    <= 1'b0;
        end else begin
            wb_valid_q     <= 1'b0;
            wb_reg_write_q <= 1'b0;
            mem_fault_q    <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (in_valid && !flush) begin
                        if (!mem_op_s) begin
                            wb_valid_q     <= 1'b1;
                            wb_reg_write_q <= reg_write;
                            wb_rd_q        <= rd;
                            wb_data_q      <= alu_out;
                        end else if (fault_s) begin
                            wb_valid_q     <= 1'b1;
                            mem_fault_q    <= 1'b1;
                            wb_rd_q        <= rd;
                            wb_data_q      <= alu_out;
                        end else begin
                            state_q      <= ST_BUSY;
                            req_q        <= 1'b1;
                            we_q         <= mem_write;
                            load_q       <= mem_read;
                            addr_q       <= {alu_out[31:2], 2'b00};
                            wdata_q      <= wdata_d;
                            wstrb_q      <= wstrb_d;
                            lane_q       <= alu_out[1:0];
                            funct3_q     <= funct3;
                            rd_q         <= rd;
                            regw_q       <= reg_write;
                            flush_seen_q <= 1'b0;
                        end
                    end
                end
                ST_BUSY: begin
                    if (dmem_ready) begin
                        // A flush seen at any point of the access kills only the writeback.
                        state_q        <= ST_IDLE;
                        req_q          <= 1'b0;
                        we_q           <= 1'b0;
                        wstrb_q        <= 4'b0000;
                        flush_seen_q   <= 1'b0;
                        wb_valid_q     <= ~(flush_seen_q | flush);
                        wb_reg_write_q <= load_q & regw_q & ~(flush_seen_q | flush);
                        wb_rd_q        <= rd_q;
                        wb_data_q      <= load_q ? load_extract(funct3_q, lane_q, dmem_rdata)
                                                 : 32'h0000_0000;
                    end else begin
                        flush_seen_q <= flush_seen_q | flush;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign dmem_req     = req_q;
    assign dmem_we      = we_q;
    assign dmem_addr    = addr_q;
    assign dmem_wdata   = wdata_q;
    assign dmem_wstrb   = wstrb_q;
    assign stall        = stall_s;
    assign wb_valid     = wb_valid_q;
    assign wb_reg_write = wb_reg_write_q;
    assign wb_rd        = wb_rd_q;
    assign wb_data      = wb_data_q;
    assign mem_fault    = mem_fault_q;

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: a driver acting as execute stage and memory,
// and a monitor checking writebacks against a byte-level reference model.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0, flush = 1'b0;
    logic [31:0] alu_out = 32'h0, store_data = 32'h0;
    logic        mem_read = 1'b0, mem_write = 1'b0;
    logic [2:0]  funct3 = 3'b000;
    logic [4:0]  rd = 5'd0;
    logic        reg_write = 1'b0;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic [3:0]  dmem_wstrb;
    logic        dmem_ready = 1'b0;
    logic [31:0] dmem_rdata = 32'h0;
    logic        stall, wb_valid, wb_reg_write, mem_fault;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;

    mem_stage dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .flush(flush),
        .alu_out(alu_out), .store_data(store_data), .mem_read(mem_read),
        .mem_write(mem_write), .funct3(funct3), .rd(rd), .reg_write(reg_write),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb), .dmem_ready(dmem_ready),
        .dmem_rdata(dmem_rdata), .stall(stall), .wb_valid(wb_valid),
        .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_data(wb_data),
        .mem_fault(mem_fault)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        logic        regw;
        logic [4:0]  rd;
        logic [31:0] data;
        logic        fault;
        bit          chk_rd;
        bit          chk_data;
    } exp_t;
    exp_t exp_q[$];

    int errors = 0;
    int checks = 0;

    logic [31:0] bmem [256];   // what the bus holds, written through DUT strobes
    logic [31:0] mmem [256];   // what the reference model believes memory holds

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic bit m_fault(input logic rdm, input logic wrm, input logic [2:0] f3,
                                   input logic [31:0] a);
        if (rdm && wrm) return 1'b1;
        case (f3)
            3'd0, 3'd4: return 1'b0;
            3'd1, 3'd5: return a[0];
            3'd2:       return a[1:0] != 2'b00;
            default:    return 1'b1;
        endcase
    endfunction

    function automatic int m_size(input logic [2:0] f3);
        return (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a);
        logic [31:0] word, v;
        word = mmem[a[9:2]];
        case (f3)
            3'd0, 3'd4: begin
                v = (word >> (8 * a[1:0])) & 32'h0000_00FF;
                if (f3 == 3'd0 && v >= 32'h80) v = v - 32'h100;
            end
            3'd1, 3'd5: begin
                v = (word >> (16 * a[1])) & 32'h0000_FFFF;
                if (f3 == 3'd1 && v >= 32'h8000) v = v - 32'h10000;
            end
            default: v = word;
        endcase
        return v;
    endfunction

    // Monitor: every writeback must match the oldest expectation, in the expected cycle.
    always @(negedge clk) begin
        if (!rst) begin
            if (wb_valid) begin
                if (exp_q.size() == 0) begin
                    chk("wb_unexpected", {31'h0, wb_valid}, 32'h0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("wb_cycle", cyc, e.cyc);
                    chk("wb_fault", {31'h0, mem_fault}, {31'h0, e.fault});
                    chk("wb_reg_write", {31'h0, wb_reg_write}, {31'h0, e.regw});
                    if (e.chk_rd) chk("wb_rd", {27'h0, wb_rd}, {27'h0, e.rd});
                    if (e.chk_data) chk("wb_data", wb_data, e.data);
                end
            end else begin
                if (mem_fault) chk("fault_without_valid", 32'h1, 32'h0);
                if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
                    chk("wb_missing", 32'h0, 32'h1);
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    // Issue one op at a negedge; for accepted memory ops also play the bus.
    task automatic do_op(input logic rdm, input logic wrm, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] sd, input logic [4:0] rdi,
                         input logic rw, input logic fl_idle, input int waits, input int flush_at);
        bit memop, flt, ok, flushed;
        logic [3:0]  es;
        logic [31:0] ew;
        int sz;
        exp_t e;
        memop = rdm | wrm;
        flt   = memop && m_fault(rdm, wrm, f3, a);
        ok    = memop && !flt;
        in_valid = 1'b1; flush = fl_idle; mem_read = rdm; mem_write = wrm;
        funct3 = f3; alu_out = a; store_data = sd; rd = rdi; reg_write = rw;
        #1;
        chk("stall_issue", {31'h0, stall}, {31'h0, ok && !fl_idle});
        if (!fl_idle && !memop) begin
            e = '{cyc + 1, rw, rdi, a, 1'b0, 1'b1, 1'b1};
            exp_q.push_back(e);
        end
        if (!fl_idle && flt) begin
            e = '{cyc + 1, 1'b0, rdi, 32'h0, 1'b1, 1'b0, 1'b0};
            exp_q.push_back(e);
        end
        @(posedge clk);
        @(negedge clk);
        if (!ok || fl_idle) begin
            chk("no_req", {31'h0, dmem_req}, 32'h0);
            in_valid = 1'b0; flush = 1'b0;
            return;
        end
        sz = m_size(f3);
        es = wrm ? 4'((32'd1 << sz) - 32'd1) << a[1:0] : 4'b0000;
        ew = (sz == 1) ? {4{sd[7:0]}} : (sz == 2) ? {2{sd[15:0]}} : sd;
        flushed = 1'b0;
        for (int w = 0; w <= waits; w++) begin
            in_valid = 1'($urandom); mem_read = 1'($urandom); mem_write = 1'($urandom);
            alu_out = $urandom; store_data = $urandom; funct3 = 3'($urandom);
            flush = (w == flush_at);
            if (w == flush_at) flushed = 1'b1;
            chk("req", {31'h0, dmem_req}, 32'h1);
            chk("addr", dmem_addr, {a[31:2], 2'b00});
            chk("we", {31'h0, dmem_we}, {31'h0, wrm});
            chk("wstrb", {28'h0, dmem_wstrb}, {28'h0, es});
            if (wrm) chk("wdata", dmem_wdata, ew);
            dmem_ready = (w == waits);
            dmem_rdata = dmem_ready ? bmem[dmem_addr[9:2]] : $urandom;
            #1;
            chk("stall_busy", {31'h0, stall}, {31'h0, !dmem_ready});
            if (dmem_ready) begin
                if (!flushed) begin
                    if (rdm) e = '{cyc + 1, rw, rdi, m_load(f3, a), 1'b0, 1'b1, 1'b1};
                    else     e = '{cyc + 1, 1'b0, rdi, 32'h0, 1'b0, 1'b0, 1'b0};
                    exp_q.push_back(e);
                end
                if (wrm) begin
                    for (int i = 0; i < 4; i++)
                        if (dmem_wstrb[i]) bmem[dmem_addr[9:2]][8*i +: 8] = dmem_wdata[8*i +: 8];
                    for (int k = 0; k < sz; k++)
                        mmem[a[9:2]][8*(a[1:0]+k) +: 8] = sd[8*k +: 8];
                end
            end
            @(posedge clk);
            @(negedge clk);
        end
        dmem_ready = 1'b0; in_valid = 1'b0; flush = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            bmem[i] = $urandom;
            mmem[i] = bmem[i];
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_req", {31'h0, dmem_req}, 32'h0);
        chk("rst_we", {31'h0, dmem_we}, 32'h0);
        chk("rst_addr", dmem_addr, 32'h0);
        chk("rst_wdata", dmem_wdata, 32'h0);
        chk("rst_wstrb", {28'h0, dmem_wstrb}, 32'h0);
        chk("rst_wb_valid", {31'h0, wb_valid}, 32'h0);
        chk("rst_wb_data", wb_data, 32'h0);
        chk("rst_fault", {31'h0, mem_fault}, 32'h0);
        rst = 1'b0;

        // Directed cases from the stage's documented behaviour.
        do_op(1'b0, 1'b0, 3'd0, 32'h0000_1234, 32'h0, 5'd5, 1'b1, 1'b0, 0, -1);
        bmem[8'h40] = 32'h80AA_BBCC; mmem[8'h40] = 32'h80AA_BBCC;
        do_op(1'b1, 1'b0, 3'd0, 32'h0000_0103, 32'h0, 5'd7, 1'b1, 1'b0, 0, -1);
        do_op(1'b1, 1'b0, 3'd4, 32'h0000_0103, 32'h0, 5'd8, 1'b1, 1'b0, 0, -1);
        do_op(1'b0, 1'b1, 3'd1, 32'h0000_0202, 32'h1234_ABCD, 5'd9, 1'b1, 1'b0, 0, -1);
        do_op(1'b1, 1'b0, 3'd1, 32'h0000_0202, 32'h0, 5'd10, 1'b1, 1'b0, 0, -1);
        do_op(1'b1, 1'b0, 3'd2, 32'h0000_0040, 32'h0, 5'd11, 1'b1, 1'b0, 3, -1);
        do_op(1'b1, 1'b0, 3'd2, 32'h0000_0041, 32'h0, 5'd12, 1'b1, 1'b0, 0, -1);
        do_op(1'b1, 1'b1, 3'd2, 32'h0000_0080, 32'h0, 5'd13, 1'b1, 1'b0, 0, -1);
        do_op(1'b0, 1'b1, 3'd2, 32'h0000_0080, 32'hDEAD_BEEF, 5'd14, 1'b0, 1'b0, 1, 0);
        do_op(1'b1, 1'b0, 3'd2, 32'h0000_0080, 32'h0, 5'd15, 1'b1, 1'b0, 0, -1);
        do_op(1'b0, 1'b0, 3'd0, 32'h0000_5555, 32'h0, 5'd16, 1'b1, 1'b1, 0, -1);

        // Randomized mix of ALU, load, store and faulting ops.
        for (int n = 0; n < 300; n++) begin
            int kind;
            logic rdm, wrm;
            logic [2:0] f3;
            logic [31:0] a;
            kind = $urandom_range(0, 9);
            a = $urandom;
            rdm = 1'b0; wrm = 1'b0; f3 = 3'($urandom);
            if (kind >= 3 && kind <= 5) begin
                rdm = 1'b1;
                case ($urandom_range(0, 4))
                    0: f3 = 3'd0; 1: f3 = 3'd1; 2: f3 = 3'd2; 3: f3 = 3'd4; default: f3 = 3'd5;
                endcase
            end else if (kind >= 6 && kind <= 8) begin
                wrm = 1'b1;
                f3 = 3'($urandom_range(0, 2));
            end else if (kind == 9) begin
                rdm = 1'b1; wrm = 1'($urandom);
            end
            if ((rdm || wrm) && $urandom_range(0, 3) != 0) begin
                if (f3[1:0] == 2'b01) a[0] = 1'b0;
                if (f3[1:0] == 2'b10) a[1:0] = 2'b00;
            end
            do_op(rdm, wrm, f3, a, $urandom, 5'($urandom), 1'($urandom),
                  ($urandom_range(0, 15) == 0), $urandom_range(0, 3),
                  ($urandom_range(0, 7) == 0) ? $urandom_range(0, 3) : -1);
        end

        // Reset while a load is waiting on the bus.
        in_valid = 1'b1; flush = 1'b0; mem_read = 1'b1; mem_write = 1'b0;
        funct3 = 3'd2; alu_out = 32'h0000_0040; rd = 5'd3; reg_write = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0; dmem_ready = 1'b0;
        chk("rstbusy_req_before", {31'h0, dmem_req}, 32'h1);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("rstbusy_req", {31'h0, dmem_req}, 32'h0);
        chk("rstbusy_addr", dmem_addr, 32'h0);
        chk("rstbusy_stall", {31'h0, stall}, 32'h0);
        chk("rstbusy_wb_valid", {31'h0, wb_valid}, 32'h0);
        chk("rstbusy_wb_data", wb_data, 32'h0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("rstbusy_idle_req", {31'h0, dmem_req}, 32'h0);
        chk("queue_drained", exp_q.size(), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1, "timeout");
    end

endmodule
